// File: rtl/imem_loader.sv
// Byte-stream program loader for the big-endian instruction memory; holds the CPU in reset until a full program is written.
// Latency: each accepted data byte appears on mem_we/mem_addr/mem_wdata one cycle after its accepting edge.
// Backpressure: in_ready is high in every load state; the stream is only stalled in IDLE/DONE/ERR.
// Optional checksum byte after the data: define LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold,
  output logic [15:0]       words_loaded
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, DONE, ERR} state_t;
`endif

  state_t            state, state_nxt;
  logic [7:0]        hdr_hi;
  logic [ADDR_W:0]   nbytes;   // 4*N, only meaningful once the load is known to fit
  logic [ADDR_W:0]   idx;      // index of the next data byte
  logic [ADDR_W:0]   idx_nxt;
  logic [17:0]       len;      // 4*N at full width so large N can never alias small
  logic              xfer;
  logic              idle_like;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign xfer      = in_valid && in_ready;
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
  assign idx_nxt   = idx + {{ADDR_W{1'b0}}, 1'b1};
  assign len       = {hdr_hi, in_data, 2'b00};

  assign in_ready  = !idle_like;
  assign busy      = !idle_like;
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign cpu_hold  = (state != DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: header parsing, length check and end-of-program detection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = HDR_HI;
      HDR_HI:          if (xfer)  state_nxt = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if ({hdr_hi, in_data} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = DONE;
`endif
          end else if (len > 18'(DEPTH)) begin
            state_nxt = ERR;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (xfer && (idx_nxt == nbytes)) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = CSUM;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: if (xfer) state_nxt = (in_data == csum) ? DONE : ERR;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: header capture, byte write strobe/address/data, word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_hi       <= 8'd0;
      nbytes       <= '0;
      idx          <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 8'd0;
      words_loaded <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (start && idle_like) begin
        idx          <= '0;
        mem_addr     <= '0;
        words_loaded <= 16'd0;
      end
      if (xfer) begin
        case (state)
          HDR_HI: begin
            hdr_hi <= in_data;
`ifdef LOADER_CHECKSUM_EN
            csum   <= in_data;
`endif
          end
          HDR_LO: begin
            nbytes <= len[ADDR_W:0];
`ifdef LOADER_CHECKSUM_EN
            csum   <= csum ^ in_data;
`endif
          end
          DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= idx[ADDR_W-1:0];
            mem_wdata <= in_data;
            idx       <= idx_nxt;
            if (idx[1:0] == 2'b11) words_loaded <= words_loaded + 16'd1;
`ifdef LOADER_CHECKSUM_EN
            csum      <= csum ^ in_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
